timer_cmp: RTL and testbench
============================

Name: timer_cmp

Overview:
- Compare/interrupt stage directly downstream of the free-running 64-bit mm timer.
- Consumes the timer's live 64-bit count, holds a programmable 64-bit compare value and raises a level interrupt when the count reaches it.
- Supports one-shot and periodic (auto-reload) modes.
- Av-mm slave on the same peripheral bus as the timer, same read timing (readdata registered, 1-cycle latency).

Parameters:
- NONE_DEFAULT_CMP, 64'hFFFF_FFFF_FFFF_FFFF, reset value of the compare register.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- mtime  in  64  live count from the timer block
- addr  in  3  word address of the register
- read  in  1  av-mm read strobe
- write  in  1  av-mm write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  level interrupt to the core

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n: sampled only at the clk rising edge.
- Register map (word addresses):
  - 0 CMP_LO (cmp[31:0])
  - 1 CMP_HI (cmp[63:32])
  - 2 CTRL: bit0 IE, bit1 AUTO
  - 3 STATUS: bit0 PEND, bit1 OVR; write-1-to-clear
  - 4 PER_LO, 5 PER_HI (64-bit period)
  - 6 MCNT: match count, read-only
  - 7 reads 0
- Unused bits read 0. Writes to 6 and 7 are ignored.
- Reset values:
  - cmp = NONE_DEFAULT_CMP; period = 0; CTRL = 0; STATUS = 0; MCNT = 0.
  - State = IDLE; readdata = 0; irq = 0.
- State machine (2 bits): IDLE, ARMED, FIRED.
  - Write CMP_LO: go to IDLE (disarm). This makes a lo-then-hi update glitch-free.
  - Write CMP_HI: go to ARMED.
  - ARMED and match: if AUTO=1 and period != 0, stay ARMED and set cmp <= cmp + period (mod 2^64, wraps silently). Otherwise go to FIRED.
  - FIRED: stays until a CMP write.
  - IDLE: no compare is performed.
- Match: unsigned mtime >= cmp, evaluated only in state ARMED.
  - A match sampled at edge N sets PEND at edge N.
  - irq = PEND & IE is driven from registers and is high from cycle N+1.
- On a match with PEND already 1: set OVR. PEND stays 1.
- MCNT increments on every match and saturates at 32'hFFFF_FFFF.
- Simultaneous events:
  - STATUS W1C in the same cycle as a match: set wins; the bit remains 1.
  - CMP write in the same cycle as a match: the write wins; no match is registered and MCNT is unchanged.
  - PER write in the same cycle as an auto-reload: the reload uses the old period.
- Reads: readdata updates on the edge after read=1, otherwise it holds. A read in the same cycle as a write returns the pre-write value.
- Reset mid-operation: all state returns to reset values on the next edge. irq drops at that edge.

Test Plan:
- Reset, then read all 8 addresses -> CMP_LO/HI = 0xFFFFFFFF; all others 0; irq = 0.
- One-shot: CTRL=1, CMP_LO=100, CMP_HI=0, drive mtime 98, 99, 100, 101 -> PEND set at the mtime=100 edge, irq=1 the next cycle, state FIRED, MCNT=1. Then mtime=200 -> MCNT stays 1.
- Periodic: CTRL=3, PER_LO=10, cmp=50, mtime stepping by 1 -> matches at 50, 60, 70. After three W1C clears, MCNT=3; cmp reads 80.
- Overrun: periodic with period 10, no clearing, mtime passes 50 and 60 -> STATUS=0x3. Write 0x3 to STATUS -> STATUS=0, irq=0.
- Boundaries:
  - cmp=0xFFFF_FFFF_FFFF_FFF8 with period 0x10 -> after the match, cmp wraps to 0x8.
  - W1C in the same cycle as a match -> PEND remains 1.
  - CMP_LO write alone while mtime > cmp -> no irq (IDLE).
- Reset mid-periodic with irq=1: assert rst_n=0 for one edge -> irq=0, CTRL=0, cmp restored, MCNT=0.

Source files
------------

// File: rtl/timer_cmp.sv
// Compare/interrupt stage for the free-running 64-bit timer: programmable compare,
// one-shot or auto-reload periodic match, level irq, Av-MM register access.
module timer_cmp #(
    parameter logic [63:0] NONE_DEFAULT_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] mtime,
    input  logic [2:0]  addr,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_t;

    state_t      state_r;
    logic [63:0] cmp_r;
    logic [63:0] per_r;
    logic        ie_r;
    logic        auto_r;
    logic        pend_r;
    logic        ovr_r;
    logic [31:0] mcnt_r;

    logic        wr_cmp_s;
    logic        w1c_s;
    logic        match_s;
    logic        reload_s;
    logic        ie_nxt_s;
    logic        auto_nxt_s;
    logic        pend_nxt_s;
    logic        ovr_nxt_s;
    logic [31:0] rd_mux_s;

    // Match qualification; a same-cycle compare write suppresses the match entirely.
    always_comb begin
        wr_cmp_s = write && ((addr == 3'd0) || (addr == 3'd1));
        w1c_s    = write && (addr == 3'd3);
        match_s  = (state_r == ARMED) && (mtime >= cmp_r) && !wr_cmp_s;
        reload_s = match_s && auto_r && (per_r != 64'd0);
    end

    // Next CTRL/STATUS values; a match sets its bits after W1C so set wins.
    always_comb begin
        if (write && (addr == 3'd2)) begin
            ie_nxt_s   = writedata[0];
            auto_nxt_s = writedata[1];
        end else begin
            ie_nxt_s   = ie_r;
            auto_nxt_s = auto_r;
        end
        pend_nxt_s = (w1c_s ? (pend_r & ~writedata[0]) : pend_r) | match_s;
        ovr_nxt_s  = (w1c_s ? (ovr_r & ~writedata[1]) : ovr_r) | (match_s & pend_r);
    end

    // Read mux over current register values, so a same-cycle write returns old data.
    always_comb begin
        case (addr)
            3'd0:    rd_mux_s = cmp_r[31:0];
            3'd1:    rd_mux_s = cmp_r[63:32];
            3'd2:    rd_mux_s = {30'd0, auto_r, ie_r};
            3'd3:    rd_mux_s = {30'd0, ovr_r, pend_r};
            3'd4:    rd_mux_s = per_r[31:0];
            3'd5:    rd_mux_s = per_r[63:32];
            3'd6:    rd_mux_s = mcnt_r;
            default: rd_mux_s = 32'd0;
        endcase
    end

    // All architectural state, FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cmp_r    <= NONE_DEFAULT_CMP;
            per_r    <= 64'd0;
            ie_r     <= 1'b0;
            auto_r   <= 1'b0;
            pend_r   <= 1'b0;
            ovr_r    <= 1'b0;
            mcnt_r   <= 32'd0;
            readdata <= 32'd0;
            irq      <= 1'b0;
        end else begin
            ie_r   <= ie_nxt_s;
            auto_r <= auto_nxt_s;
            pend_r <= pend_nxt_s;
            ovr_r  <= ovr_nxt_s;
            irq    <= pend_nxt_s & ie_nxt_s;

            if (read) begin
                readdata <= rd_mux_s;
            end else begin
                readdata <= readdata;
            end

            if (match_s && (mcnt_r != 32'hFFFF_FFFF)) begin
                mcnt_r <= mcnt_r + 32'd1;
            end else begin
                mcnt_r <= mcnt_r;
            end

            // Reload uses per_r as it stood before any same-cycle PER write.
            if (reload_s) begin
                cmp_r   <= cmp_r + per_r;
                state_r <= ARMED;
            end else if (match_s) begin
                state_r <= FIRED;
            end else begin
                state_r <= state_r;
            end

            // Writing the low half disarms so a lo-then-hi update cannot match midway.
            if (write) begin
                case (addr)
                    3'd0: begin
                        cmp_r[31:0] <= writedata;
                        state_r     <= IDLE;
                    end
                    3'd1: begin
                        cmp_r[63:32] <= writedata;
                        state_r      <= ARMED;
                    end
                    3'd4:    per_r[31:0]  <= writedata;
                    3'd5:    per_r[63:32] <= writedata;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_cmp.sv
// Directed self-checking bench for timer_cmp.
module tb_timer_cmp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] mtime = 64'd0;
    logic [2:0]  addr = 3'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        irq;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    timer_cmp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mtime     (mtime),
        .addr      (addr),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        write = 1'b1; addr = a; writedata = d;
        tick();
        write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        read = 1'b1; addr = a;
        tick();
        read = 1'b0;
        chk(tag, readdata, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic arm(input logic [63:0] c);
        wr(3'd0, c[31:0]);
        wr(3'd1, c[63:32]);
    endtask

    initial begin
        // Reset state
        tick();
        do_reset();
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        rd(3'd0, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(3'd1, 32'hFFFF_FFFF, "rst_cmp_hi");
        for (int a = 2; a < 8; a++) rd(a[2:0], 32'd0, "rst_reg");

        // Read in the same cycle as a write returns the old value
        write = 1'b1; read = 1'b1; addr = 3'd2; writedata = 32'd3;
        tick();
        write = 1'b0; read = 1'b0;
        chk("rd_wr_same_cycle", readdata, 32'd0);
        rd(3'd2, 32'd3, "ctrl_after_wr");
        wr(3'd6, 32'h55);
        rd(3'd6, 32'd0, "mcnt_ro");

        // One-shot
        wr(3'd2, 32'd1);
        mtime = 64'd98;
        arm(64'd100);
        tick();
        mtime = 64'd99; tick();
        chk("os_irq_before", {31'd0, irq}, 32'd0);
        mtime = 64'd100; tick();
        chk("os_irq_match", {31'd0, irq}, 32'd1);
        mtime = 64'd101; tick();
        rd(3'd3, 32'd1, "os_status");
        rd(3'd6, 32'd1, "os_mcnt");
        mtime = 64'd200; tick(); tick();
        rd(3'd6, 32'd1, "os_mcnt_fired");

        // Periodic with a W1C after every match
        do_reset();
        wr(3'd2, 32'd3);
        wr(3'd4, 32'd10);
        mtime = 64'd40;
        arm(64'd50);
        for (int m = 41; m <= 75; m++) begin
            mtime = 64'(m);
            tick();
            if (m == 50 || m == 60 || m == 70) begin
                chk("per_irq_set", {31'd0, irq}, 32'd1);
                wr(3'd3, 32'd1);
                chk("per_irq_clr", {31'd0, irq}, 32'd0);
            end
        end
        rd(3'd6, 32'd3, "per_mcnt");
        rd(3'd0, 32'd80, "per_cmp_lo");
        rd(3'd1, 32'd0, "per_cmp_hi");

        // Overrun
        do_reset();
        wr(3'd2, 32'd3);
        wr(3'd4, 32'd10);
        mtime = 64'd40;
        arm(64'd50);
        for (int m = 41; m <= 65; m++) begin
            mtime = 64'(m);
            tick();
        end
        rd(3'd3, 32'd3, "ovr_status");
        chk("ovr_irq", {31'd0, irq}, 32'd1);
        rd(3'd6, 32'd2, "ovr_mcnt");
        wr(3'd3, 32'd3);
        rd(3'd3, 32'd0, "ovr_cleared");
        chk("ovr_irq_clr", {31'd0, irq}, 32'd0);

        // Compare wraps modulo 2^64 on reload
        do_reset();
        wr(3'd2, 32'd3);
        wr(3'd4, 32'h10);
        mtime = 64'hFFFF_FFFF_FFFF_FFF0;
        arm(64'hFFFF_FFFF_FFFF_FFF8);
        mtime = 64'hFFFF_FFFF_FFFF_FFF8;
        tick();
        mtime = 64'd0;
        chk("wrap_irq", {31'd0, irq}, 32'd1);
        rd(3'd0, 32'd8, "wrap_cmp_lo");
        rd(3'd1, 32'd0, "wrap_cmp_hi");

        // W1C in the same cycle as a match: set wins
        do_reset();
        wr(3'd2, 32'd1);
        mtime = 64'd0;
        arm(64'd20);
        mtime = 64'd20;
        wr(3'd3, 32'd1);
        chk("w1c_match_irq", {31'd0, irq}, 32'd1);
        rd(3'd3, 32'd1, "w1c_match_status");
        rd(3'd6, 32'd1, "w1c_match_mcnt");

        // CMP_LO alone disarms: no match while mtime > cmp
        wr(3'd3, 32'd3);
        mtime = 64'd1000;
        wr(3'd0, 32'd5);
        tick(); tick(); tick();
        chk("idle_irq", {31'd0, irq}, 32'd0);
        rd(3'd3, 32'd0, "idle_status");
        rd(3'd6, 32'd1, "idle_mcnt");

        // Reset in the middle of periodic operation with irq high
        do_reset();
        wr(3'd2, 32'd3);
        wr(3'd4, 32'd10);
        mtime = 64'd0;
        arm(64'd5);
        mtime = 64'd5;
        tick();
        chk("mid_irq_high", {31'd0, irq}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_irq_rst", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        rd(3'd2, 32'd0, "mid_ctrl");
        rd(3'd0, 32'hFFFF_FFFF, "mid_cmp_lo");
        rd(3'd1, 32'hFFFF_FFFF, "mid_cmp_hi");
        rd(3'd6, 32'd0, "mid_mcnt");
        rd(3'd4, 32'd0, "mid_per");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
